// File: rtl/operand_pair_sync_pkg.sv
// Shared defaults and helpers for operand_pair_sync and its lane FIFOs.
package operand_pair_sync_pkg;

  localparam int unsigned DEF_N     = 16;
  localparam int unsigned DEF_DEPTH = 4;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = (v > 0) ? v - 1 : 0;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/operand_pair_sync_fifo.sv
// Single-lane circular FIFO; the caller only asserts push when space exists or a pop frees a slot.
module stream_lane_fifo
  import operand_pair_sync_pkg::*;
#(
  parameter int unsigned N     = DEF_N,
  parameter int unsigned DEPTH = DEF_DEPTH,
  localparam int unsigned AW   = clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          push,
  input  logic [N-1:0]  din,
  input  logic          pop,
  output logic [N-1:0]  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [N-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_next;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/operand_pair_sync.sv
// Pairs two skewed operand streams through per-lane FIFOs and releases aligned pairs.
// Optional macro OPERAND_PAIR_SYNC_BYPASS_EN: simultaneous arrivals into empty FIFOs skip buffering.
module operand_pair_sync
  import operand_pair_sync_pkg::*;
#(
  parameter int unsigned N     = DEF_N,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         EN,
  input  logic         R_IN1,
  input  logic [N-1:0] D_IN1,
  input  logic         R_IN2,
  input  logic [N-1:0] D_IN2,
  output logic         R_OUT1,
  output logic [N-1:0] D_OUT1,
  output logic         R_OUT2,
  output logic [N-1:0] D_OUT2,
  output logic         FULL1,
  output logic         FULL2,
  output logic         OVF
);

  localparam int unsigned CW = clog2(DEPTH) + 1;

  logic [N-1:0]  head1, head2;
  logic [CW-1:0] count1, count2;
  logic          full1, full2, empty1, empty2;
  logic          pop, push1, push2, bypass, drop;
  logic          r_out;

  always_comb begin
    pop = EN && (count1 != '0) && (count2 != '0);
`ifdef OPERAND_PAIR_SYNC_BYPASS_EN
    bypass = EN && empty1 && empty2 && R_IN1 && R_IN2;
`else
    bypass = 1'b0;
`endif
    // A full lane still accepts when the pair pop frees its head slot this edge.
    push1 = EN && R_IN1 && !bypass && (!full1 || pop);
    push2 = EN && R_IN2 && !bypass && (!full2 || pop);
    drop  = EN && ((R_IN1 && full1 && !pop) || (R_IN2 && full2 && !pop));
  end

  stream_lane_fifo #(.N(N), .DEPTH(DEPTH)) u_lane1 (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push1),
    .din   (D_IN1),
    .pop   (pop),
    .head  (head1),
    .count (count1),
    .full  (full1),
    .empty (empty1)
  );

  stream_lane_fifo #(.N(N), .DEPTH(DEPTH)) u_lane2 (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push2),
    .din   (D_IN2),
    .pop   (pop),
    .head  (head2),
    .count (count2),
    .full  (full2),
    .empty (empty2)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_out  <= 1'b0;
      D_OUT1 <= '0;
      D_OUT2 <= '0;
      OVF    <= 1'b0;
    end else if (EN) begin
      if (pop) begin
        r_out  <= 1'b1;
        D_OUT1 <= head1;
        D_OUT2 <= head2;
      end else if (bypass) begin
        r_out  <= 1'b1;
        D_OUT1 <= D_IN1;
        D_OUT2 <= D_IN2;
      end else begin
        r_out <= 1'b0;
      end
      if (drop) OVF <= 1'b1;
    end
  end

  assign R_OUT1 = r_out;
  assign R_OUT2 = r_out;
  assign FULL1  = full1;
  assign FULL2  = full2;

endmodule

// File: tb/tb_operand_pair_sync.sv
// Directed cycle-by-cycle vectors for operand_pair_sync (default build, N=16, DEPTH=4).
module tb_operand_pair_sync;

  logic        CLK = 1'b0;
  logic        RST, EN, R_IN1, R_IN2;
  logic [15:0] D_IN1, D_IN2;
  logic        R_OUT1, R_OUT2, FULL1, FULL2, OVF;
  logic [15:0] D_OUT1, D_OUT2;

  int tests  = 0;
  int errors = 0;

  operand_pair_sync #(.N(16), .DEPTH(4)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .EN     (EN),
    .R_IN1  (R_IN1),
    .D_IN1  (D_IN1),
    .R_IN2  (R_IN2),
    .D_IN2  (D_IN2),
    .R_OUT1 (R_OUT1),
    .D_OUT1 (D_OUT1),
    .R_OUT2 (R_OUT2),
    .D_OUT2 (D_OUT2),
    .FULL1  (FULL1),
    .FULL2  (FULL2),
    .OVF    (OVF)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst, en, r1, r2;
    logic [15:0] d1, d2;
    logic        er;
    logic [15:0] ed1, ed2;
    logic        ef1, ef2, eovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic en, logic r1, logic [15:0] d1,
                              logic r2, logic [15:0] d2, logic er,
                              logic [15:0] ed1, logic [15:0] ed2,
                              logic ef1, logic ef2, logic eovf);
    vec_t v;
    v.rst = rst; v.en = en; v.r1 = r1; v.d1 = d1; v.r2 = r2; v.d2 = d2;
    v.er = er; v.ed1 = ed1; v.ed2 = ed2; v.ef1 = ef1; v.ef2 = ef2; v.eovf = eovf;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic en, input logic r1,
                       input logic [15:0] d1, input logic r2, input logic [15:0] d2);
    RST = rst; EN = en; R_IN1 = r1; D_IN1 = d1; R_IN2 = r2; D_IN2 = d2;
    @(posedge CLK);
    #1;
  endtask

  task automatic check_all(input int idx, input logic er, input logic [15:0] ed1,
                           input logic [15:0] ed2, input logic ef1, input logic ef2,
                           input logic eovf);
    check("R_OUT1", idx, 16'(R_OUT1), 16'(er));
    check("R_OUT2", idx, 16'(R_OUT2), 16'(er));
    check("D_OUT1", idx, D_OUT1, ed1);
    check("D_OUT2", idx, D_OUT2, ed2);
    check("FULL1",  idx, 16'(FULL1), 16'(ef1));
    check("FULL2",  idx, 16'(FULL2), 16'(ef2));
    check("OVF",    idx, 16'(OVF), 16'(eovf));
  endtask

  initial begin
    RST = 1'b1; EN = 1'b0; R_IN1 = 1'b0; R_IN2 = 1'b0; D_IN1 = '0; D_IN2 = '0;

    // rst en r1 d1 r2 d2 | er ed1 ed2 ef1 ef2 eovf
    // reset while disabled, then one aligned pair (2-edge latency)
    vecs.push_back(mk(1,0, 0,16'h0000, 0,16'h0000, 0,16'h0000,16'h0000, 0,0,0));
    vecs.push_back(mk(0,1, 1,16'h00F0, 1,16'h0FF0, 0,16'h0000,16'h0000, 0,0,0));
    vecs.push_back(mk(0,1, 0,16'h0000, 0,16'h0000, 1,16'h00F0,16'h0FF0, 0,0,0));
    vecs.push_back(mk(0,1, 0,16'h0000, 0,16'h0000, 0,16'h00F0,16'h0FF0, 0,0,0));
    // skew: lane 1 leads lane 2 by three cycles
    vecs.push_back(mk(0,1, 1,16'h0001, 0,16'h0000, 0,16'h00F0,16'h0FF0, 0,0,0));
    vecs.push_back(mk(0,1, 1,16'h0002, 0,16'h0000, 0,16'h00F0,16'h0FF0, 0,0,0));
    vecs.push_back(mk(0,1, 1,16'h0003, 0,16'h0000, 0,16'h00F0,16'h0FF0, 0,0,0));
    vecs.push_back(mk(0,1, 0,16'h0000, 1,16'h0011, 0,16'h00F0,16'h0FF0, 0,0,0));
    vecs.push_back(mk(0,1, 0,16'h0000, 1,16'h0012, 1,16'h0001,16'h0011, 0,0,0));
    vecs.push_back(mk(0,1, 0,16'h0000, 1,16'h0013, 1,16'h0002,16'h0012, 0,0,0));
    vecs.push_back(mk(0,1, 0,16'h0000, 0,16'h0000, 1,16'h0003,16'h0013, 0,0,0));
    vecs.push_back(mk(0,1, 0,16'h0000, 0,16'h0000, 0,16'h0003,16'h0013, 0,0,0));
    // overflow: fifth lane-1 item dropped
    vecs.push_back(mk(0,1, 1,16'h0101, 0,16'h0000, 0,16'h0003,16'h0013, 0,0,0));
    vecs.push_back(mk(0,1, 1,16'h0102, 0,16'h0000, 0,16'h0003,16'h0013, 0,0,0));
    vecs.push_back(mk(0,1, 1,16'h0103, 0,16'h0000, 0,16'h0003,16'h0013, 0,0,0));
    vecs.push_back(mk(0,1, 1,16'h0104, 0,16'h0000, 0,16'h0003,16'h0013, 1,0,0));
    vecs.push_back(mk(0,1, 1,16'h0105, 0,16'h0000, 0,16'h0003,16'h0013, 1,0,1));
    vecs.push_back(mk(0,1, 0,16'h0000, 1,16'h0201, 0,16'h0003,16'h0013, 1,0,1));
    vecs.push_back(mk(0,1, 0,16'h0000, 1,16'h0202, 1,16'h0101,16'h0201, 0,0,1));
    vecs.push_back(mk(0,1, 0,16'h0000, 1,16'h0203, 1,16'h0102,16'h0202, 0,0,1));
    vecs.push_back(mk(0,1, 0,16'h0000, 1,16'h0204, 1,16'h0103,16'h0203, 0,0,1));
    vecs.push_back(mk(0,1, 0,16'h0000, 0,16'h0000, 1,16'h0104,16'h0204, 0,0,1));
    vecs.push_back(mk(0,1, 0,16'h0000, 0,16'h0000, 0,16'h0104,16'h0204, 0,0,1));
    // reset clears OVF; then push into a full lane while a pair pops
    vecs.push_back(mk(1,1, 0,16'h0000, 0,16'h0000, 0,16'h0000,16'h0000, 0,0,0));
    vecs.push_back(mk(0,1, 1,16'h1001, 0,16'h0000, 0,16'h0000,16'h0000, 0,0,0));
    vecs.push_back(mk(0,1, 1,16'h1002, 0,16'h0000, 0,16'h0000,16'h0000, 0,0,0));
    vecs.push_back(mk(0,1, 1,16'h1003, 0,16'h0000, 0,16'h0000,16'h0000, 0,0,0));
    vecs.push_back(mk(0,1, 1,16'h1004, 0,16'h0000, 0,16'h0000,16'h0000, 1,0,0));
    vecs.push_back(mk(0,1, 0,16'h0000, 1,16'h2001, 0,16'h0000,16'h0000, 1,0,0));
    vecs.push_back(mk(0,1, 1,16'hAAAA, 1,16'h5555, 1,16'h1001,16'h2001, 1,0,0));
    vecs.push_back(mk(0,1, 1,16'hBBBB, 1,16'h6666, 1,16'h1002,16'h5555, 1,0,0));
    vecs.push_back(mk(0,1, 0,16'h0000, 0,16'h0000, 1,16'h1003,16'h6666, 0,0,0));
    vecs.push_back(mk(0,1, 0,16'h0000, 1,16'h7001, 0,16'h1003,16'h6666, 0,0,0));
    vecs.push_back(mk(0,1, 0,16'h0000, 1,16'h7002, 1,16'h1004,16'h7001, 0,0,0));
    vecs.push_back(mk(0,1, 0,16'h0000, 1,16'h7003, 1,16'hAAAA,16'h7002, 0,0,0));
    vecs.push_back(mk(0,1, 0,16'h0000, 0,16'h0000, 1,16'hBBBB,16'h7003, 0,0,0));
    vecs.push_back(mk(0,1, 0,16'h0000, 0,16'h0000, 0,16'hBBBB,16'h7003, 0,0,0));
    // EN=0 freeze with two pairs buffered and R_OUT high
    vecs.push_back(mk(0,1, 1,16'h3001, 0,16'h0000, 0,16'hBBBB,16'h7003, 0,0,0));
    vecs.push_back(mk(0,1, 1,16'h3002, 0,16'h0000, 0,16'hBBBB,16'h7003, 0,0,0));
    vecs.push_back(mk(0,1, 0,16'h0000, 1,16'h4001, 0,16'hBBBB,16'h7003, 0,0,0));
    vecs.push_back(mk(0,1, 0,16'h0000, 1,16'h4002, 1,16'h3001,16'h4001, 0,0,0));
    vecs.push_back(mk(0,0, 1,16'h9999, 1,16'h8888, 1,16'h3001,16'h4001, 0,0,0));
    vecs.push_back(mk(0,0, 1,16'h9999, 1,16'h8888, 1,16'h3001,16'h4001, 0,0,0));
    vecs.push_back(mk(0,0, 1,16'h9999, 1,16'h8888, 1,16'h3001,16'h4001, 0,0,0));
    vecs.push_back(mk(0,1, 0,16'h0000, 0,16'h0000, 1,16'h3002,16'h4002, 0,0,0));
    vecs.push_back(mk(0,1, 0,16'h0000, 0,16'h0000, 0,16'h3002,16'h4002, 0,0,0));
    vecs.push_back(mk(0,1, 0,16'h0000, 0,16'h0000, 0,16'h3002,16'h4002, 0,0,0));
    // reset mid-stream discards lane-1 entries
    vecs.push_back(mk(0,1, 1,16'h5001, 0,16'h0000, 0,16'h3002,16'h4002, 0,0,0));
    vecs.push_back(mk(0,1, 1,16'h5002, 0,16'h0000, 0,16'h3002,16'h4002, 0,0,0));
    vecs.push_back(mk(0,1, 1,16'h5003, 0,16'h0000, 0,16'h3002,16'h4002, 0,0,0));
    vecs.push_back(mk(1,1, 0,16'h0000, 0,16'h0000, 0,16'h0000,16'h0000, 0,0,0));
    vecs.push_back(mk(0,1, 0,16'h0000, 1,16'h6001, 0,16'h0000,16'h0000, 0,0,0));
    vecs.push_back(mk(0,1, 0,16'h0000, 0,16'h0000, 0,16'h0000,16'h0000, 0,0,0));
    vecs.push_back(mk(0,1, 0,16'h0000, 0,16'h0000, 0,16'h0000,16'h0000, 0,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].r1, vecs[i].d1, vecs[i].r2, vecs[i].d2);
      check_all(i, vecs[i].er, vecs[i].ed1, vecs[i].ed2,
                vecs[i].ef1, vecs[i].ef2, vecs[i].eovf);
    end

    // back-to-back stream: one pair per cycle after a single-edge fill
    drive(1, 1, 0, 16'h0000, 0, 16'h0000);
    check_all(1000, 0, 16'h0000, 16'h0000, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 1, 16'hC000 + 16'(i), 1, 16'hD000 + 16'(i));
      if (i == 0)
        check_all(1001 + i, 0, 16'h0000, 16'h0000, 0, 0, 0);
      else
        check_all(1001 + i, 1, 16'hC000 + 16'(i - 1), 16'hD000 + 16'(i - 1), 0, 0, 0);
    end
    drive(0, 1, 0, 16'h0000, 0, 16'h0000);
    check_all(1009, 1, 16'hC007, 16'hD007, 0, 0, 0);
    drive(0, 1, 0, 16'h0000, 0, 16'h0000);
    check_all(1010, 0, 16'hC007, 16'hD007, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
